// File: rtl/spm_dac_pkg.sv
// Shared definitions for the SPM six-lane DAC SPI output stage.
// Command codes, frame geometry, config bit map and FSM states.
package spm_dac_pkg;

  localparam logic [3:0] CMD_WR_DAC  = 4'b0001;
  localparam logic [3:0] CMD_WR_CTRL = 4'b0010;

  localparam int FRAME_BITS = 24;

  localparam int CFG_ENABLE   = 0;
  localparam int CFG_INIT     = 1;
  localparam int CFG_TWOS     = 2;
  localparam int CFG_CTRL_LSB = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_LDAC
  } state_t;

endpackage

// File: rtl/q31_to_dac20.sv
// Q31 -> 20-bit DAC code: round-half-up on the dropped LSBs,
// saturate the positive overflow, optional offset-binary MSB flip.
module q31_to_dac20 #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 20
) (
  input  logic [IN_W-1:0]  x,
  input  logic             twos_comp,
  output logic [OUT_W-1:0] d
);

  logic [OUT_W+1:0] sum;
  logic [OUT_W:0]   half;
  logic [OUT_W-1:0] sat;
  logic             unused_lsb;

  assign unused_lsb = ^x[IN_W-OUT_W-2:0];

  assign sum  = {x[IN_W-1], x[IN_W-1 -: OUT_W+1]}
              + (OUT_W+2)'(1);
  assign half = sum[OUT_W+1:1];

  always_comb begin
    sat = half[OUT_W-1:0];
    if (!half[OUT_W] && half[OUT_W-1])
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (half[OUT_W] && !half[OUT_W-1])
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    d = sat;
    d[OUT_W-1] = sat[OUT_W-1] ^ ~twos_comp;
  end

endmodule

// File: rtl/axis_spm_dac_spi.sv
// Six-lane AD5791 SPI output stage: shared SCLK/SYNC, one SDIN per
// channel, common LDAC so all channels update on the same edge.
module axis_spm_dac_spi
  import spm_dac_pkg::*;
#(
  parameter int          SAXIS_TDATA_WIDTH      = 32,
  parameter int          DAC_WIDTH              = 20,
  parameter int          SCLK_DIV               = 4,
  parameter logic [31:0] dac_config_reg_address = 32'd1110
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic [31:0]                  config_addr,
  input  logic [511:0]                 config_data,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS1_tdata,
  input  logic                         S_AXIS1_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS2_tdata,
  input  logic                         S_AXIS2_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS3_tdata,
  input  logic                         S_AXIS3_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS4_tdata,
  input  logic                         S_AXIS4_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS5_tdata,
  input  logic                         S_AXIS5_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS6_tdata,
  input  logic                         S_AXIS6_tvalid,
  output logic                         dac_sclk,
  output logic                         dac_sync_n,
  output logic [5:0]                   dac_sdin,
  output logic                         dac_ldac_n,
  output logic                         busy,
  output logic [31:0]                  frame_count
);

  localparam int NCH = 6;
  localparam int DW  = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [4:0]    BIT_TOP  = 5'(FRAME_BITS - 1);

  logic [SAXIS_TDATA_WIDTH-1:0]   tdata [NCH];
  logic [NCH-1:0]                 tvalid;
  logic [NCH-1:0][DAC_WIDTH-1:0]  conv;
  logic [NCH-1:0][DAC_WIDTH-1:0]  word_q, word_d;
  logic [NCH-1:0][FRAME_BITS-1:0] frame_q, frame_d;

  logic                 enable, twos_comp, init_pending;
  logic                 cfg_hit;
  logic [DAC_WIDTH-1:0] ctrl_word;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic          hi_q, hi_d;
  logic          is_init_q, is_init_d;
  logic          load_init, load_data, count_inc, div_last;

  logic           shifting;
  logic           sclk_d, sync_n_d, ldac_n_d, busy_d;
  logic [NCH-1:0] sdin_d;
  logic           unused_cfg;

  assign tdata[0] = S_AXIS1_tdata;
  assign tdata[1] = S_AXIS2_tdata;
  assign tdata[2] = S_AXIS3_tdata;
  assign tdata[3] = S_AXIS4_tdata;
  assign tdata[4] = S_AXIS5_tdata;
  assign tdata[5] = S_AXIS6_tdata;
  assign tvalid = {S_AXIS6_tvalid, S_AXIS5_tvalid,
                   S_AXIS4_tvalid, S_AXIS3_tvalid,
                   S_AXIS2_tvalid, S_AXIS1_tvalid};

  for (genvar g = 0; g < NCH; g++) begin : g_conv
    q31_to_dac20 #(
      .IN_W (SAXIS_TDATA_WIDTH),
      .OUT_W(DAC_WIDTH)
    ) u_conv (
      .x        (tdata[g]),
      .twos_comp(twos_comp),
      .d        (conv[g])
    );
  end

  assign cfg_hit    = (config_addr == dac_config_reg_address);
  assign unused_cfg = ^{config_data[511:CFG_CTRL_LSB+DAC_WIDTH],
                        config_data[CFG_CTRL_LSB-1:CFG_TWOS+1]};

  // A fresh init request wins over the clear of the one being served.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      enable       <= 1'b0;
      twos_comp    <= 1'b0;
      init_pending <= 1'b0;
      ctrl_word    <= '0;
    end else begin
      if (load_init)
        init_pending <= 1'b0;
      if (cfg_hit) begin
        enable    <= config_data[CFG_ENABLE];
        twos_comp <= config_data[CFG_TWOS];
        ctrl_word <= config_data[CFG_CTRL_LSB +: DAC_WIDTH];
        if (config_data[CFG_INIT])
          init_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    word_d  = word_q;
    frame_d = frame_q;
    for (int i = 0; i < NCH; i++) begin
      if (load_data && tvalid[i])
        word_d[i] = conv[i];
      if (load_init)
        frame_d[i] = {CMD_WR_CTRL, ctrl_word};
      else if (load_data)
        frame_d[i] = {CMD_WR_DAC, word_d[i]};
    end
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      word_q  <= '0;
      frame_q <= '0;
    end else begin
      word_q  <= word_d;
      frame_q <= frame_d;
    end
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= BIT_TOP;
      hi_q      <= 1'b0;
      is_init_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      hi_q      <= hi_d;
      is_init_q <= is_init_d;
    end
  end

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    hi_d      = hi_q;
    is_init_d = is_init_q;
    load_init = 1'b0;
    load_data = 1'b0;
    count_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = BIT_TOP;
        if (init_pending) begin
          load_init = 1'b1;
          is_init_d = 1'b1;
          state_d   = S_SETUP;
        end else if (enable) begin
          load_data = 1'b1;
          is_init_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        div_d = div_q + DW'(1);
        if (div_last) begin
          div_d   = '0;
          hi_d    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      // Each bit: SCLK high half, then low half; DAC samples on the fall.
      S_SHIFT: begin
        div_d = div_q + DW'(1);
        if (div_last) begin
          div_d = '0;
          if (hi_q) begin
            hi_d = 1'b0;
          end else if (bit_q == 5'd0) begin
            state_d = S_GAP;
          end else begin
            hi_d  = 1'b1;
            bit_d = bit_q - 5'd1;
          end
        end
      end
      S_GAP: begin
        div_d = div_q + DW'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = is_init_q ? S_IDLE : S_LDAC;
        end
      end
      S_LDAC: begin
        div_d = div_q + DW'(1);
        if (div_last) begin
          div_d     = '0;
          count_inc = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they can be registered
  // without lagging the FSM by a cycle.
  always_comb begin
    shifting = (state_d == S_SETUP) || (state_d == S_SHIFT);
    sclk_d   = (state_d == S_SHIFT) && hi_d;
    sync_n_d = !shifting;
    ldac_n_d = (state_d != S_LDAC);
    busy_d   = (state_d != S_IDLE);
    sdin_d   = '0;
    for (int i = 0; i < NCH; i++)
      sdin_d[i] = shifting && frame_d[i][bit_d];
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      dac_sclk    <= 1'b0;
      dac_sync_n  <= 1'b1;
      dac_sdin    <= '0;
      dac_ldac_n  <= 1'b1;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      dac_sclk   <= sclk_d;
      dac_sync_n <= sync_n_d;
      dac_sdin   <= sdin_d;
      dac_ldac_n <= ldac_n_d;
      busy       <= busy_d;
      if (count_inc)
        frame_count <= frame_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_spm_dac_spi.sv
// Scoreboard bench for axis_spm_dac_spi: planned frames are queued from
// a Q31 arithmetic model; a pin monitor decodes SPI/LDAC and compares.
module tb_axis_spm_dac_spi;

  typedef struct {
    logic [5:0][23:0] w;
    bit               init;
  } frame_t;

  logic         a_clk = 1'b0;
  logic         a_rst;
  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic [31:0]  td [6];
  logic [5:0]   tv;
  logic         dac_sclk, dac_sync_n, dac_ldac_n, dac_busy;
  logic [5:0]   dac_sdin;
  logic [31:0]  frame_count;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  frame_t expq[$];

  bit          m_en, m_tc, m_initp;
  logic [19:0] m_ctrl;
  logic [19:0] m_last [6];
  bit          planned_init;
  bit          prev_was_init;
  int          prev_start;

  axis_spm_dac_spi dut (
    .a_clk         (a_clk),
    .a_rst         (a_rst),
    .config_addr   (config_addr),
    .config_data   (config_data),
    .S_AXIS1_tdata (td[0]),
    .S_AXIS1_tvalid(tv[0]),
    .S_AXIS2_tdata (td[1]),
    .S_AXIS2_tvalid(tv[1]),
    .S_AXIS3_tdata (td[2]),
    .S_AXIS3_tvalid(tv[2]),
    .S_AXIS4_tdata (td[3]),
    .S_AXIS4_tvalid(tv[3]),
    .S_AXIS5_tdata (td[4]),
    .S_AXIS5_tvalid(tv[4]),
    .S_AXIS6_tdata (td[5]),
    .S_AXIS6_tvalid(tv[5]),
    .dac_sclk      (dac_sclk),
    .dac_sync_n    (dac_sync_n),
    .dac_sdin      (dac_sdin),
    .dac_ldac_n    (dac_ldac_n),
    .busy          (dac_busy),
    .frame_count   (frame_count)
  );

  always #5 a_clk = ~a_clk;

  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor(x/2^11), then round half up by one more bit.
  function automatic logic [19:0] ref_word(input logic [31:0] x,
                                           input bit tc);
    int v;
    logic [19:0] r;
    v = $signed(x) >>> 11;
    v = (v + 1) >>> 1;
    if (v > 524287)  v = 524287;
    if (v < -524288) v = -524288;
    r = 20'(v);
    if (!tc) r[19] = ~r[19];
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic             p_sclk = 1'b0, p_sync = 1'b1, p_ldac = 1'b1;
  logic [5:0][23:0] cap;
  int               nbits, ldac_len, exp_fc, t_sync;
  bit               need_ldac;

  always @(negedge a_clk) begin
    if (a_rst) begin
      p_sclk = 1'b0; p_sync = 1'b1; p_ldac = 1'b1;
      nbits = 0; ldac_len = 0; exp_fc = 0; need_ldac = 0;
    end else begin
      if (p_sync && !dac_sync_n) begin
        chk("ldac_before_next_frame", 32'(need_ldac), 0);
        nbits = 0;
        cap = '0;
        t_sync = cyc;
      end
      if (!dac_sync_n && p_sclk && !dac_sclk) begin
        for (int i = 0; i < 6; i++)
          cap[i] = {cap[i][22:0], dac_sdin[i]};
        nbits++;
      end
      if (!p_sync && dac_sync_n) begin
        chk("frame_bits", nbits, 24);
        chk("frame_was_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          frame_t e;
          e = expq.pop_front();
          for (int i = 0; i < 6; i++)
            chk($sformatf("lane%0d_word", i), 32'(cap[i]), 32'(e.w[i]));
          need_ldac = !e.init;
        end
      end
      if (!dac_ldac_n) begin
        if (p_ldac) begin
          chk("ldac_expected", 32'(need_ldac), 1);
          chk("ldac_latency", cyc - t_sync, 200);
        end
        ldac_len++;
      end
      if (!p_ldac && dac_ldac_n) begin
        chk("ldac_width", ldac_len, 4);
        ldac_len = 0;
        need_ldac = 0;
        exp_fc++;
        chk("frame_count", frame_count, exp_fc);
      end
      p_sclk = dac_sclk; p_sync = dac_sync_n; p_ldac = dac_ldac_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg(input bit en, input bit init, input bit tc,
                     input logic [19:0] ctrl);
    @(negedge a_clk);
    config_addr = 32'd1110;
    config_data = '0;
    config_data[0] = en;
    config_data[1] = init;
    config_data[2] = tc;
    config_data[51:32] = ctrl;
    @(negedge a_clk);
    config_addr = '0;
    config_data = '0;
    m_en = en; m_tc = tc; m_ctrl = ctrl;
    if (init) m_initp = 1;
  endtask

  task automatic plan();
    frame_t f;
    if (m_initp) begin
      for (int i = 0; i < 6; i++) f.w[i] = {4'b0010, m_ctrl};
      f.init = 1;
      m_initp = 0;
      planned_init = 1;
      expq.push_back(f);
    end else if (m_en) begin
      for (int i = 0; i < 6; i++) begin
        if (tv[i]) m_last[i] = ref_word(td[i], m_tc);
        f.w[i] = {4'b0001, m_last[i]};
      end
      f.init = 0;
      planned_init = 0;
      expq.push_back(f);
    end
  endtask

  task automatic step();
    int n;
    n = 0;
    while (dac_sync_n !== 1'b1 && n < 2000) begin
      @(negedge a_clk); n++;
    end
    while (dac_sync_n !== 1'b0 && n < 2000) begin
      @(negedge a_clk); n++;
    end
    chk("frame_started", 32'(dac_sync_n), 0);
    chk("busy_in_frame", 32'(dac_busy), 1);
    if (prev_start >= 0)
      chk("frame_period", cyc - prev_start, prev_was_init ? 201 : 205);
    prev_start = cyc;
    prev_was_init = planned_init;
  endtask

  task automatic drain();
    repeat (600) @(negedge a_clk);
    chk("idle_busy", 32'(dac_busy), 0);
    chk("queue_drained", expq.size(), 0);
    prev_start = -1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [7];
    corner = '{32'h7FFFFFFF, 32'h80000000, 32'h00000800,
               32'h000007FF, 32'hFFFFF800, 32'h7FFFF800, 32'h7FFFF7FF};
    if ($urandom_range(3) == 0) return corner[$urandom_range(6)];
    return $urandom;
  endfunction

  task automatic reset_mid_frame();
    int rises, n;
    logic ps;
    rises = 0; n = 0; ps = dac_sclk;
    while (rises < 14 && n < 1000) begin
      @(negedge a_clk); n++;
      if (!ps && dac_sclk) rises++;
      ps = dac_sclk;
    end
    chk("reached_bit10", rises, 14);
    a_rst = 1'b1;
    #1;
    chk("rst_sync_n", 32'(dac_sync_n), 1);
    chk("rst_sclk", 32'(dac_sclk), 0);
    chk("rst_ldac_n", 32'(dac_ldac_n), 1);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", 32'(dac_busy), 0);
    expq.delete();
    m_en = 0; m_tc = 0; m_initp = 0; m_ctrl = '0;
    for (int i = 0; i < 6; i++) m_last[i] = '0;
    prev_start = -1;
    repeat (3) @(negedge a_clk);
    a_rst = 1'b0;
    repeat (300) @(negedge a_clk);
    chk("post_rst_sync_n", 32'(dac_sync_n), 1);
    chk("post_rst_frame_count", frame_count, 0);
  endtask

  initial begin
    a_rst = 1'b1;
    config_addr = '0;
    config_data = '0;
    for (int i = 0; i < 6; i++) begin
      td[i] = '0;
      m_last[i] = '0;
    end
    tv = 6'h3F;
    m_en = 0; m_tc = 0; m_initp = 0; m_ctrl = '0;
    planned_init = 0; prev_was_init = 0; prev_start = -1;

    repeat (3) @(negedge a_clk);
    chk("reset_sclk", 32'(dac_sclk), 0);
    chk("reset_sync_n", 32'(dac_sync_n), 1);
    chk("reset_sdin", 32'(dac_sdin), 0);
    chk("reset_ldac_n", 32'(dac_ldac_n), 1);
    chk("reset_busy", 32'(dac_busy), 0);
    chk("reset_frame_count", frame_count, 0);
    a_rst = 1'b0;

    // Offset binary, X at zero
    for (int i = 1; i < 6; i++) td[i] = $urandom;
    cfg(1, 0, 0, 20'h0);
    plan(); step();

    // Full-scale both ends, two's complement
    td[0] = 32'h7FFFFFFF; td[1] = 32'h80000000;
    cfg(1, 0, 1, 20'h0);
    plan(); step();

    // Rounding boundary
    td[0] = 32'h00000800; td[1] = 32'h000007FF;
    plan(); step();

    // Init request lands mid-SHIFT of the frame above
    repeat (100) @(negedge a_clk);
    cfg(1, 1, 1, 20'h00012);
    plan(); step();
    plan(); step();

    // Channel B holds its word when tvalid drops
    td[5] = 32'h40000000;
    plan(); step();
    tv[5] = 1'b0;
    td[5] = $urandom;
    plan(); step();

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 6; i++) td[i] = pick();
      tv = 6'($urandom);
      if ($urandom_range(3) == 0)
        cfg(1, $urandom_range(7) == 0, $urandom_range(1) == 1,
            20'($urandom));
      plan(); step();
    end

    // Disable mid-frame: frame and LDAC complete, then idle
    cfg(0, 0, m_tc, m_ctrl);
    plan();
    drain();

    // Asynchronous reset at bit 10, then a clean restart
    tv = 6'h3F;
    for (int i = 0; i < 6; i++) td[i] = pick();
    cfg(1, 0, 1, 20'h0);
    plan(); step();
    reset_mid_frame();

    for (int i = 0; i < 6; i++) td[i] = pick();
    cfg(1, 0, 1, 20'h0);
    plan(); step();
    for (int i = 0; i < 6; i++) td[i] = pick();
    plan(); step();
    cfg(0, 0, 1, 20'h0);
    plan();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
